// File: rtl/shift_array_pipe_if.sv
// Valid/ready operand and result channels of the pipelined barrel shifter.
// The master drives operands and consumes results; the slave is the shifter.
interface shift_array_pipe_if #(
  parameter int unsigned WIDTH = 8
) ();
  localparam int unsigned SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/shift_array_pipe.sv
// Pipelined barrel shifter (LSL/LSR/ASR/ROL): stage k shifts by 2^k when amt bit k is set.
// Elastic valid/ready pipeline; empty stages absorb data even while downstream stalls.
module shift_array_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_array_pipe_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [1:0] ModeLsl = 2'b00;
  localparam logic [1:0] ModeLsr = 2'b01;
  localparam logic [1:0] ModeAsr = 2'b10;
  localparam logic [1:0] ModeRol = 2'b11;

  logic [SHW-1:0]   valid_q;
  logic [WIDTH-1:0] data_q  [SHW];
  logic [SHW-1:0]   amt_q   [SHW];
  logic [1:0]       mode_q  [SHW];
  logic [SHW-1:0]   sign_q;

  logic [SHW-1:0]   ready;
  logic [SHW-1:0]   vin;
  logic [WIDTH-1:0] din     [SHW];
  logic [SHW-1:0]   ain     [SHW];
  logic [1:0]       min     [SHW];
  logic [SHW-1:0]   sin;
  logic [WIDTH-1:0] shifted [SHW];

  function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       mode,
                                                   input logic             sign,
                                                   input int unsigned      s);
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] fill;
    fill = ~({WIDTH{1'b1}} >> s);
    case (mode)
      ModeLsl: res = d << s;
      ModeLsr: res = d >> s;
      ModeAsr: res = (d >> s) | (sign ? fill : '0);
      ModeRol: res = (d << s) | (d >> (WIDTH - s));
      default: res = d;
    endcase
    return res;
  endfunction

  // Ready ripples back from out_ready; an empty stage is always ready.
  always_comb begin
    logic chain;
    chain = bus.out_ready;
    ready = '0;
    for (int k = SHW - 1; k >= 0; k--) begin
      chain    = ~valid_q[k] | chain;
      ready[k] = chain;
    end
  end

  always_comb begin
    vin = '0;
    sin = '0;
    for (int k = 0; k < SHW; k++) begin
      if (k == 0) begin
        vin[k] = bus.in_valid;
        din[k] = bus.in_data;
        ain[k] = bus.in_amt;
        min[k] = bus.in_mode;
        sin[k] = bus.in_data[WIDTH-1];
      end else begin
        vin[k] = valid_q[k-1];
        din[k] = data_q[k-1];
        ain[k] = amt_q[k-1];
        min[k] = mode_q[k-1];
        sin[k] = sign_q[k-1];
      end
      shifted[k] = ain[k][k] ? shift_stage(din[k], min[k], sin[k], 32'd1 << k) : din[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      sign_q  <= '0;
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        mode_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (ready[k]) begin
          valid_q[k] <= vin[k];
          // Bubbles only clear the valid flag; payload keeps its last value.
          if (vin[k]) begin
            data_q[k] <= shifted[k];
            amt_q[k]  <= ain[k];
            mode_q[k] <= min[k];
            sign_q[k] <= sin[k];
          end
        end
      end
    end
  end

  assign bus.in_ready  = rst_n & ready[0];
  assign bus.out_valid = valid_q[SHW-1];
  assign bus.out_data  = data_q[SHW-1];
  assign bus.out_zero  = ~|data_q[SHW-1];

  // Last-stage control fields have no consumer downstream.
  logic unused_last;
  assign unused_last = ^{amt_q[SHW-1], mode_q[SHW-1], sign_q[SHW-1]};
endmodule

// File: tb/tb_shift_array_pipe.sv
// Scoreboard bench for shift_array_pipe (WIDTH=8): expected results queued at accept,
// compared in order at each output handshake, with latency checked where the pipe is free-flowing.
module tb_shift_array_pipe;
  localparam int unsigned WIDTH = 8;

  typedef struct {
    logic [7:0] d;
    logic       z;
    int         cyc;
    bit         lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   cyc;
  bit   lat_en;
  exp_t sb[$];

  shift_array_pipe_if #(.WIDTH(WIDTH)) bus ();

  shift_array_pipe #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] d, input int a, input logic [1:0] m);
    logic [15:0] w;
    case (m)
      2'b00: return d << a;
      2'b01: return d >> a;
      2'b10: return 8'($signed(d) >>> a);
      default: begin
        w = {d, d} << a;
        return w[15:8];
      end
    endcase
  endfunction

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        e.d   = model(bus.in_data, int'(bus.in_amt), bus.in_mode);
        e.z   = (e.d == 8'h00);
        e.cyc = cyc;
        e.lat = lat_en;
        sb.push_back(e);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("out_data", 32'(bus.out_data), 32'(e.d));
          check_eq("out_zero", 32'(bus.out_zero), 32'(e.z));
          if (e.lat) check_eq("latency", 32'(cyc - e.cyc), 32'd3);
        end
      end
    end
  end

  // Called aligned at posedge+1; returns aligned at posedge+1 after the accepting edge.
  task automatic drive(input logic [7:0] d, input int a, input logic [1:0] m, output int stalls);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = 3'(a);
    bus.in_mode  = m;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      stalls++;
    end
    if (stalls >= 100) check_eq("accept_timeout", 32'(stalls), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hxx;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) check_eq("drain_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    int tot;
    logic [7:0] held;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    lat_en = 1'b1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_amt = '0;
    bus.in_mode = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
    check_eq("rst_out_zero", 32'(bus.out_zero), 32'd1);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Single ops, all modes, amt 3 and 0.
    drive(8'hB5, 3, 2'b00, st);
    idle();
    drain();
    for (int m = 0; m < 4; m++) begin
      drive(8'hB5, 3, 2'(m), st);
      drive(8'hB5, 0, 2'(m), st);
    end
    idle();
    drain();

    // Streaming: 8 back-to-back LSL on 0x01, no stalls allowed.
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      drive(8'h01, i, 2'b00, st);
      tot += st;
    end
    idle();
    check_eq("stream_stalls", 32'(tot), 32'd0);
    drain();

    // Backpressure: three accepts fill the pipe, then in_ready drops and output holds.
    lat_en = 1'b0;
    bus.out_ready = 1'b0;
    drive(8'h3C, 1, 2'b01, st);
    drive(8'h81, 2, 2'b11, st);
    drive(8'h90, 4, 2'b10, st);
    idle();
    @(negedge clk);
    check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
    held = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_stable", 32'(bus.out_data), 32'(held));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();
    lat_en = 1'b1;

    // Zero flag.
    drive(8'h80, 1, 2'b00, st);
    drive(8'h80, 7, 2'b10, st);
    drive(8'h6D, 7, 2'b00, st);
    drive(8'h6D, 5, 2'b11, st);
    idle();
    drain();

    // Reset with two ops in flight.
    drive(8'h55, 2, 2'b00, st);
    drive(8'hAA, 1, 2'b01, st);
    idle();
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) tot++;
    end
    check_eq("no_stale", 32'(tot), 32'd0);
    @(posedge clk);
    #1;
    drive(8'hC3, 2, 2'b11, st);
    idle();
    drain();
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
